// File: rtl/gray_updown_counter.sv
// Multi-channel up/down Gray-code counter with load, clear, wrap or saturate.
// Latency: one cycle; inputs sampled on a rising edge appear on the outputs after that edge.
// Backpressure: none; every channel accepts a command on every cycle.
//
// Ports (channel c uses bit c of the per-channel vectors and bits [c*WIDTH +: WIDTH] of the wide buses):
//   i_clk, i_rst   clock and asynchronous active-high reset
//   i_clr          synchronous clear to RESET_VALUE (highest priority)
//   i_load         synchronous load of the binary value on i_load_val
//   i_en, i_dn     count enable and direction (0 = up, 1 = down)
//   o_gray, o_bin  registered Gray count and its registered binary equivalent
//   o_wrap         one-cycle pulse on rollover (wrap mode) or blocked step (saturate mode)
//   o_at_max/min   registered flags: binary count is all ones / zero
//
// WIDTH must be at least 2 and NUM_CH at least 1.
module gray_updown_counter #(
   parameter int                 WIDTH       = 4,
   parameter int                 NUM_CH      = 1,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   parameter bit                 SATURATE    = 1'b0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_CH-1:0]         i_clr,
   input  logic [NUM_CH-1:0]         i_load,
   input  logic [NUM_CH*WIDTH-1:0]   i_load_val,
   input  logic [NUM_CH-1:0]         i_en,
   input  logic [NUM_CH-1:0]         i_dn,
   output logic [NUM_CH*WIDTH-1:0]   o_gray,
   output logic [NUM_CH*WIDTH-1:0]   o_bin,
   output logic [NUM_CH-1:0]         o_wrap,
   output logic [NUM_CH-1:0]         o_at_max,
   output logic [NUM_CH-1:0]         o_at_min
);

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reset/clear targets are resolved at elaboration so the reset path is constants only.
   localparam logic [WIDTH-1:0] RESET_BIN    = gray2bin(RESET_VALUE);
   localparam logic             RESET_AT_MAX = (RESET_BIN == {WIDTH{1'b1}});
   localparam logic             RESET_AT_MIN = (RESET_BIN == {WIDTH{1'b0}});
   localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [WIDTH-1:0] gray_d, gray_q;
      logic [WIDTH-1:0] bin_d, bin_q;
      logic             wrap_d, wrap_q;
      logic             at_max_d, at_max_q;
      logic             at_min_d, at_min_q;
      logic [WIDTH-1:0] step_bin;
      logic             at_bound;

      always_comb begin
         bin_d    = bin_q;
         wrap_d   = 1'b0;
         step_bin = i_dn[c] ? (bin_q - ONE) : (bin_q + ONE);
         // Boundary in the direction of travel; the modulo arithmetic above already
         // produces the wrapped value, saturate mode simply refuses to take it.
         at_bound = i_dn[c] ? (bin_q == {WIDTH{1'b0}}) : (bin_q == {WIDTH{1'b1}});

         if (i_clr[c]) begin
            bin_d = RESET_BIN;
         end else if (i_load[c]) begin
            bin_d = i_load_val[c*WIDTH +: WIDTH];
         end else if (i_en[c]) begin
            wrap_d = at_bound;
            if (!(SATURATE && at_bound)) begin
               bin_d = step_bin;
            end
         end

         // Gray is derived from the next binary value so both registers always agree
         // and a single count step moves exactly one Gray bit.
         gray_d   = bin2gray(bin_d);
         at_max_d = &bin_d;
         at_min_d = ~|bin_d;
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            gray_q   <= RESET_VALUE;
            bin_q    <= RESET_BIN;
            wrap_q   <= 1'b0;
            at_max_q <= RESET_AT_MAX;
            at_min_q <= RESET_AT_MIN;
         end else begin
            gray_q   <= gray_d;
            bin_q    <= bin_d;
            wrap_q   <= wrap_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
         end
      end

      assign o_gray[c*WIDTH +: WIDTH] = gray_q;
      assign o_bin[c*WIDTH +: WIDTH]  = bin_q;
      assign o_wrap[c]                = wrap_q;
      assign o_at_max[c]              = at_max_q;
      assign o_at_min[c]              = at_min_q;
   end

endmodule

// File: tb/tb_gray_updown_counter.sv
module tb_gray_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Instances A (wrap) and B (saturate) share one single-channel stimulus.
   logic        ab_clr, ab_load, ab_en, ab_dn;
   logic [3:0]  ab_load_val;
   logic [3:0]  a_gray, a_bin, b_gray, b_bin;
   logic        a_wrap, a_max, a_min, b_wrap, b_max, b_min;

   // Instance C: three channels, RESET_VALUE = 0011 (binary 2), wrap mode.
   logic [2:0]  c_clr, c_load, c_en, c_dn, c_wrap, c_max, c_min;
   logic [11:0] c_load_val, c_gray, c_bin;

   gray_updown_counter #(.WIDTH(4), .NUM_CH(1), .RESET_VALUE(4'b0000), .SATURATE(1'b0)) u_a (
      .i_clk(clk), .i_rst(rst), .i_clr(ab_clr), .i_load(ab_load), .i_load_val(ab_load_val),
      .i_en(ab_en), .i_dn(ab_dn), .o_gray(a_gray), .o_bin(a_bin), .o_wrap(a_wrap),
      .o_at_max(a_max), .o_at_min(a_min));

   gray_updown_counter #(.WIDTH(4), .NUM_CH(1), .RESET_VALUE(4'b0000), .SATURATE(1'b1)) u_b (
      .i_clk(clk), .i_rst(rst), .i_clr(ab_clr), .i_load(ab_load), .i_load_val(ab_load_val),
      .i_en(ab_en), .i_dn(ab_dn), .o_gray(b_gray), .o_bin(b_bin), .o_wrap(b_wrap),
      .o_at_max(b_max), .o_at_min(b_min));

   gray_updown_counter #(.WIDTH(4), .NUM_CH(3), .RESET_VALUE(4'b0011), .SATURATE(1'b0)) u_c (
      .i_clk(clk), .i_rst(rst), .i_clr(c_clr), .i_load(c_load), .i_load_val(c_load_val),
      .i_en(c_en), .i_dn(c_dn), .o_gray(c_gray), .o_bin(c_bin), .o_wrap(c_wrap),
      .o_at_max(c_max), .o_at_min(c_min));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: one integer count per channel (0 = A, 1 = B, 2..4 = C ch0..2).
   int m_bin  [5];
   bit m_wrap [5];
   bit m_step [5];
   int m_prev [5];

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int rv_bin(input int k);
      return (k >= 2) ? 2 : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 5; k++) begin
         m_bin[k]  = rv_bin(k);
         m_wrap[k] = 1'b0;
         m_step[k] = 1'b0;
         m_prev[k] = gray_of(m_bin[k]);
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 5; k++) begin
         bit clr, ld, en, dn;
         int lv, nxt;
         if (k < 2) begin
            clr = ab_clr; ld = ab_load; lv = int'(ab_load_val); en = ab_en; dn = ab_dn;
         end else begin
            clr = c_clr[k-2]; ld = c_load[k-2]; lv = int'(c_load_val[(k-2)*4 +: 4]);
            en = c_en[k-2]; dn = c_dn[k-2];
         end
         m_prev[k] = gray_of(m_bin[k]);
         m_wrap[k] = 1'b0;
         m_step[k] = 1'b0;
         if (clr) begin
            m_bin[k] = rv_bin(k);
         end else if (ld) begin
            m_bin[k] = lv;
         end else if (en) begin
            nxt = dn ? m_bin[k] - 1 : m_bin[k] + 1;
            if (nxt < 0 || nxt > 15) begin
               m_wrap[k] = 1'b1;
               if (k != 1) begin
                  m_bin[k]  = (nxt + 16) % 16;
                  m_step[k] = 1'b1;
               end
            end else begin
               m_bin[k]  = nxt;
               m_step[k] = 1'b1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      for (int k = 0; k < 5; k++) begin
         logic [3:0]  g, b;
         logic        w, mx, mn;
         logic [31:0] diff;
         if (k == 0) begin
            g = a_gray; b = a_bin; w = a_wrap; mx = a_max; mn = a_min;
         end else if (k == 1) begin
            g = b_gray; b = b_bin; w = b_wrap; mx = b_max; mn = b_min;
         end else begin
            g = c_gray[(k-2)*4 +: 4]; b = c_bin[(k-2)*4 +: 4];
            w = c_wrap[k-2]; mx = c_max[k-2]; mn = c_min[k-2];
         end
         chk($sformatf("%s k%0d gray", where, k), g, gray_of(m_bin[k]));
         chk($sformatf("%s k%0d bin", where, k), b, m_bin[k]);
         chk($sformatf("%s k%0d wrap", where, k), w, m_wrap[k]);
         chk($sformatf("%s k%0d at_max", where, k), mx, (m_bin[k] == 15));
         chk($sformatf("%s k%0d at_min", where, k), mn, (m_bin[k] == 0));
         if (m_step[k]) begin
            diff = {28'b0, g} ^ m_prev[k];
            chk($sformatf("%s k%0d one_bit_flip", where, k), $countones(diff), 1);
         end
      end
   endtask

   task automatic tick(input string where);
      @(posedge clk);
      model_edge();
      #1;
      check_all(where);
   endtask

   task automatic idle();
      ab_clr = 0; ab_load = 0; ab_en = 0; ab_dn = 0; ab_load_val = '0;
      c_clr = '0; c_load = '0; c_en = '0; c_dn = '0; c_load_val = '0;
   endtask

   task automatic async_reset(input string where);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all(where);
      chk({where, " c_gray"}, c_gray, 12'h333);
      chk({where, " c_bin"}, c_bin, 12'h222);
      chk({where, " c_wrap"}, c_wrap, 3'b000);
      chk({where, " c_min"}, c_min, 3'b000);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #2;
      model_reset();
      check_all("reset");
      chk("reset a_gray", a_gray, 4'b0000);
      chk("reset c_gray", c_gray, 12'h333);
      chk("reset c_min", c_min, 3'b000);
      #5 rst = 1'b0;

      // Up count for 17 cycles: A wraps once at 1000->0000, B saturates at 1000.
      ab_en = 1; ab_dn = 0;
      for (int i = 1; i <= 17; i++) begin
         tick($sformatf("up%0d", i));
         if (i == 3)  chk("up3 a_gray", a_gray, 4'b0010);
         if (i == 15) chk("up15 a_gray", a_gray, 4'b1000);
         if (i == 16) begin
            chk("up16 a_gray", a_gray, 4'b0000);
            chk("up16 a_wrap", a_wrap, 1'b1);
            chk("up16 b_gray", b_gray, 4'b1000);
            chk("up16 b_wrap", b_wrap, 1'b1);
         end
         if (i == 17) begin
            chk("up17 a_gray", a_gray, 4'b0001);
            chk("up17 a_wrap", a_wrap, 1'b0);
         end
      end

      // Down from zero.
      ab_clr = 1; tick("clr");
      ab_clr = 0; ab_dn = 1;
      tick("dn1");
      chk("dn1 a_gray", a_gray, 4'b1000);
      chk("dn1 a_wrap", a_wrap, 1'b1);
      chk("dn1 a_max", a_max, 1'b1);
      tick("dn2");
      chk("dn2 a_gray", a_gray, 4'b1001);

      // Load beats a simultaneous up-step.
      ab_load = 1; ab_load_val = 4'd10; ab_dn = 0;
      tick("load10");
      chk("load10 a_bin", a_bin, 4'd10);
      chk("load10 a_gray", a_gray, 4'b1111);

      // Saturation from 14.
      ab_load_val = 4'd14; tick("load14");
      ab_load = 0;
      tick("sat1");
      chk("sat1 b_gray", b_gray, 4'b1000);
      chk("sat1 b_max", b_max, 1'b1);
      tick("sat2");
      chk("sat2 b_gray", b_gray, 4'b1000);
      chk("sat2 b_wrap", b_wrap, 1'b1);
      ab_dn = 1;
      tick("sat3");
      chk("sat3 b_gray", b_gray, 4'b1001);
      chk("sat3 b_wrap", b_wrap, 1'b0);

      // Independent channels; ch2 has clear and load together, clear wins.
      idle();
      c_en = 3'b011; c_dn = 3'b010; c_clr = 3'b100; c_load = 3'b100; c_load_val = 12'h900;
      for (int i = 0; i < 5; i++) tick($sformatf("mc%0d", i));
      chk("mc ch2 gray", c_gray[11:8], 4'b0011);
      chk("mc ch2 bin", c_bin[11:8], 4'd2);

      // Async reset while counting at bin 7.
      idle();
      c_load = 3'b111; c_load_val = 12'h777;
      tick("load7");
      c_load = '0; c_en = 3'b111;
      async_reset("arst");
      tick("resume");
      chk("resume c_gray", c_gray, 12'h222);
      chk("resume c_bin", c_bin, 12'h333);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         ab_clr = ($urandom % 16) == 0;
         ab_load = ($urandom % 8) == 0;
         ab_load_val = 4'($urandom);
         ab_en = ($urandom % 4) != 0;
         ab_dn = 1'($urandom);
         for (int c = 0; c < 3; c++) begin
            c_clr[c]  = ($urandom % 16) == 0;
            c_load[c] = ($urandom % 8) == 0;
            c_en[c]   = ($urandom % 4) != 0;
            c_dn[c]   = 1'($urandom);
         end
         c_load_val = 12'($urandom);
         if (($urandom % 64) == 0) async_reset($sformatf("rnd_arst%0d", i));
         tick($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
